// File: rtl/semaforo_pkg.sv
// Shared encodings for the traffic-light lamp monitor: phase codes, lamp
// patterns and monitor state.
package semaforo_pkg;

    localparam logic [1:0] PH_GREEN   = 2'b00;
    localparam logic [1:0] PH_YELLOW  = 2'b01;
    localparam logic [1:0] PH_RED     = 2'b10;
    localparam logic [1:0] PH_UNKNOWN = 2'b11;

    // Lamp patterns are ordered {green, yellow, red}.
    localparam logic [2:0] PAT_G = 3'b100;
    localparam logic [2:0] PAT_Y = 3'b010;
    localparam logic [2:0] PAT_R = 3'b001;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_RED    = 3'd3,
        ST_FAULT  = 3'd4
    } mon_state_t;

    function automatic logic is_legal(input logic [2:0] pat);
        return (pat == PAT_G) || (pat == PAT_Y) || (pat == PAT_R);
    endfunction

    function automatic logic [1:0] state_phase(input mon_state_t st);
        logic [1:0] ph;
        ph = PH_UNKNOWN;
        case (st)
            ST_GREEN:  ph = PH_GREEN;
            ST_YELLOW: ph = PH_YELLOW;
            ST_RED:    ph = PH_RED;
            default:   ph = PH_UNKNOWN;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/semaforo_run_counter.sv
// 8-bit saturating run-length counter: loads 1 when a new pattern starts,
// otherwise counts up and sticks at 255.
module semaforo_run_counter (
    input  logic       newClock,
    input  logic       rst,
    input  logic       i_load,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge newClock or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= 8'd1;
        end else if (r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker on the controller lamp outputs: decodes phase, checks phase
// lengths and G->Y->R order, flags errors and counts correct cycles.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SYNC   | after reset, waiting for the first legal-to-legal change
//   ST_GREEN  | green phase being measured
//   ST_YELLOW | yellow phase being measured
//   ST_RED    | red phase being measured
//   ST_FAULT  | order/pattern error seen, waiting for a change into green
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int unsigned GREEN_LEN  = 6,
    parameter int unsigned YELLOW_LEN = 3,
    parameter int unsigned RED_LEN    = 5
) (
    input  logic       newClock,
    input  logic       rst,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    output logic [1:0] phase,
    output logic       err_len,
    output logic       err_order,
    output logic       err_pattern,
    output logic       cycle_done,
    output logic [7:0] cycle_count
);

    localparam logic [7:0] LEN_G = 8'(GREEN_LEN);
    localparam logic [7:0] LEN_Y = 8'(YELLOW_LEN);
    localparam logic [7:0] LEN_R = 8'(RED_LEN);

    mon_state_t r_state;
    mon_state_t w_state_nxt;
    logic [2:0] r_prev_pat;
    logic       r_cycle_ok;
    logic [1:0] r_phase;
    logic       r_err_len;
    logic       r_err_order;
    logic       r_err_pattern;
    logic       r_cycle_done;
    logic [7:0] r_cycle_count;

    logic [2:0] w_pat;
    logic       w_changed;
    logic       w_legal_now;
    logic       w_legal_prev;
    logic [7:0] w_run_len;
    logic       w_set_len;
    logic       w_set_order;
    logic       w_set_pat;
    logic       w_cycle_hit;
    logic       w_cycle_ok_nxt;

    assign w_pat        = {green, yellow, red};
    assign w_changed    = (w_pat != r_prev_pat);
    assign w_legal_now  = is_legal(w_pat);
    assign w_legal_prev = is_legal(r_prev_pat);

    // Holds the length of the run that ends at this edge when w_changed is set.
    semaforo_run_counter u_run_counter (
        .newClock (newClock),
        .rst      (rst),
        .i_load   (w_changed),
        .o_count  (w_run_len)
    );

    always_ff @(posedge newClock or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_SYNC;
            r_prev_pat    <= 3'b000;
            r_cycle_ok    <= 1'b0;
            r_phase       <= PH_UNKNOWN;
            r_err_len     <= 1'b0;
            r_err_order   <= 1'b0;
            r_err_pattern <= 1'b0;
            r_cycle_done  <= 1'b0;
            r_cycle_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_pat    <= w_pat;
            r_cycle_ok    <= w_cycle_ok_nxt;
            r_phase       <= state_phase(w_state_nxt);
            r_err_len     <= r_err_len | w_set_len;
            r_err_order   <= r_err_order | w_set_order;
            r_err_pattern <= r_err_pattern | w_set_pat;
            r_cycle_done  <= w_cycle_hit;
            if (w_cycle_hit && (r_cycle_count != 8'hFF)) begin
                r_cycle_count <= r_cycle_count + 8'd1;
            end
        end
    end

    // Illegal patterns win over everything; order errors skip the length check.
    always_comb begin
        w_state_nxt    = r_state;
        w_set_len      = 1'b0;
        w_set_order    = 1'b0;
        w_set_pat      = 1'b0;
        w_cycle_hit    = 1'b0;
        w_cycle_ok_nxt = r_cycle_ok;

        if (!w_legal_now) begin
            w_set_pat      = 1'b1;
            w_state_nxt    = ST_FAULT;
            w_cycle_ok_nxt = 1'b0;
        end else if (w_changed) begin
            case (r_state)
                ST_SYNC: begin
                    if (w_legal_prev) begin
                        case (w_pat)
                            PAT_G:   w_state_nxt = ST_GREEN;
                            PAT_Y:   w_state_nxt = ST_YELLOW;
                            PAT_R:   w_state_nxt = ST_RED;
                            default: w_state_nxt = ST_SYNC;
                        endcase
                    end
                end
                ST_GREEN: begin
                    if (w_pat == PAT_Y) begin
                        w_state_nxt = ST_YELLOW;
                        if (w_run_len == LEN_G) begin
                            w_cycle_ok_nxt = 1'b1;
                        end else begin
                            w_set_len      = 1'b1;
                            w_cycle_ok_nxt = 1'b0;
                        end
                    end else begin
                        w_set_order    = 1'b1;
                        w_state_nxt    = ST_FAULT;
                        w_cycle_ok_nxt = 1'b0;
                    end
                end
                ST_YELLOW: begin
                    if (w_pat == PAT_R) begin
                        w_state_nxt = ST_RED;
                        if (w_run_len != LEN_Y) begin
                            w_set_len      = 1'b1;
                            w_cycle_ok_nxt = 1'b0;
                        end
                    end else begin
                        w_set_order    = 1'b1;
                        w_state_nxt    = ST_FAULT;
                        w_cycle_ok_nxt = 1'b0;
                    end
                end
                ST_RED: begin
                    if (w_pat == PAT_G) begin
                        w_state_nxt    = ST_GREEN;
                        w_cycle_ok_nxt = 1'b0;
                        if (w_run_len == LEN_R) begin
                            w_cycle_hit = r_cycle_ok;
                        end else begin
                            w_set_len = 1'b1;
                        end
                    end else begin
                        w_set_order    = 1'b1;
                        w_state_nxt    = ST_FAULT;
                        w_cycle_ok_nxt = 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (w_pat == PAT_G) begin
                        w_state_nxt    = ST_GREEN;
                        w_cycle_ok_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt    = ST_SYNC;
                    w_cycle_ok_nxt = 1'b0;
                end
            endcase
        end
    end

    assign phase       = r_phase;
    assign err_len     = r_err_len;
    assign err_order   = r_err_order;
    assign err_pattern = r_err_pattern;
    assign cycle_done  = r_cycle_done;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: lamp sequences driven tick by tick,
// expected outputs queued per tick and compared one tick later.
module tb_semaforo_monitor;

    logic       newClock;
    logic       rst;
    logic       green;
    logic       yellow;
    logic       red;
    logic [1:0] phase;
    logic       err_len;
    logic       err_order;
    logic       err_pattern;
    logic       cycle_done;
    logic [7:0] cycle_count;

    localparam logic [2:0] G   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] R   = 3'b001;
    localparam logic [2:0] GY  = 3'b110;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    semaforo_monitor #(
        .GREEN_LEN  (6),
        .YELLOW_LEN (3),
        .RED_LEN    (5)
    ) dut (
        .newClock    (newClock),
        .rst         (rst),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .phase       (phase),
        .err_len     (err_len),
        .err_order   (err_order),
        .err_pattern (err_pattern),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count)
    );

    initial newClock = 1'b0;
    always #5 newClock = ~newClock;

    function automatic logic [13:0] pack(input logic [1:0] ph, input logic el, input logic eo,
                                         input logic ep, input logic dn, input logic [7:0] cnt);
        return {ph, el, eo, ep, dn, cnt};
    endfunction

    task automatic check();
        exp_t        e;
        logic [13:0] o;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb.pop_front();
        o = {phase, err_len, err_order, err_pattern, cycle_done, cycle_count};
        n_vec++;
        assert (o === e.v) else begin
            n_err++;
            $error("FAIL %s: got ph=%b el=%b eo=%b ep=%b done=%b cnt=%0d, want ph=%b el=%b eo=%b ep=%b done=%b cnt=%0d",
                   e.tag, o[13:12], o[11], o[10], o[9], o[8], o[7:0],
                   e.v[13:12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
        end
    endtask

    // Hold one pattern for n ticks; cycle_done is expected only on the first.
    task automatic seg(input logic [2:0] pat, input int n, input logic [1:0] ph,
                       input logic el, input logic eo, input logic ep,
                       input logic done1, input logic [7:0] cnt, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge newClock);
            {green, yellow, red} = pat;
            sb.push_back('{pack(ph, el, eo, ep, (i == 0) ? done1 : 1'b0, cnt), tag});
            @(posedge newClock);
            #1;
            check();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want end of sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        {green, yellow, red} = G;
        #2 rst = 1'b0;
        #1;
        sb.push_back('{pack(2'b11, 0, 0, 0, 0, 8'd0), "reset"});
        check();
        @(negedge newClock);
        rst = 1'b1;

        // First cycle after reset: green unchecked while syncing.
        seg(G, 6, 2'b11, 0, 0, 0, 0, 8'd0, "sync_g");
        seg(Y, 3, 2'b01, 0, 0, 0, 0, 8'd0, "sync_y");
        seg(R, 5, 2'b10, 0, 0, 0, 0, 8'd0, "sync_r");
        seg(G, 6, 2'b00, 0, 0, 0, 0, 8'd0, "first_g_no_done");

        // Two correct cycles.
        seg(Y, 3, 2'b01, 0, 0, 0, 0, 8'd0, "c1_y");
        seg(R, 5, 2'b10, 0, 0, 0, 0, 8'd0, "c1_r");
        seg(G, 6, 2'b00, 0, 0, 0, 1, 8'd1, "c1_done");
        seg(Y, 3, 2'b01, 0, 0, 0, 0, 8'd1, "c2_y");
        seg(R, 5, 2'b10, 0, 0, 0, 0, 8'd1, "c2_r");
        seg(G, 6, 2'b00, 0, 0, 0, 1, 8'd2, "c2_done");

        // Green one tick too long.
        seg(G, 1, 2'b00, 0, 0, 0, 0, 8'd2, "long_g");
        seg(Y, 3, 2'b01, 1, 0, 0, 0, 8'd2, "errlen_y");
        seg(R, 5, 2'b10, 1, 0, 0, 0, 8'd2, "errlen_r");
        seg(G, 6, 2'b00, 1, 0, 0, 0, 8'd2, "errlen_no_done");
        seg(Y, 3, 2'b01, 1, 0, 0, 0, 8'd2, "c3_y");
        seg(R, 5, 2'b10, 1, 0, 0, 0, 8'd2, "c3_r");
        seg(G, 6, 2'b00, 1, 0, 0, 1, 8'd3, "c3_done");

        // Skip yellow: order fault, recovery through green.
        seg(R, 5, 2'b11, 1, 1, 0, 0, 8'd3, "order_r");
        seg(Y, 3, 2'b11, 1, 1, 0, 0, 8'd3, "fault_y");
        seg(G, 6, 2'b00, 1, 1, 0, 0, 8'd3, "recover_g");
        seg(Y, 3, 2'b01, 1, 1, 0, 0, 8'd3, "c4_y");
        seg(R, 5, 2'b10, 1, 1, 0, 0, 8'd3, "c4_r");
        seg(G, 6, 2'b00, 1, 1, 0, 1, 8'd4, "c4_done");

        // Two-lamp glitch during yellow.
        seg(Y,  1, 2'b01, 1, 1, 0, 0, 8'd4, "pre_glitch_y");
        seg(GY, 1, 2'b11, 1, 1, 1, 0, 8'd4, "glitch");
        seg(Y,  2, 2'b11, 1, 1, 1, 0, 8'd4, "fault_y2");
        seg(R,  5, 2'b11, 1, 1, 1, 0, 8'd4, "fault_r2");
        seg(G,  6, 2'b00, 1, 1, 1, 0, 8'd4, "recover_g2");
        seg(Y,  3, 2'b01, 1, 1, 1, 0, 8'd4, "c5_y");
        seg(R,  5, 2'b10, 1, 1, 1, 0, 8'd4, "c5_r");
        seg(G,  6, 2'b00, 1, 1, 1, 1, 8'd5, "c5_done");

        // Asynchronous reset in the middle of red.
        seg(Y, 3, 2'b01, 1, 1, 1, 0, 8'd5, "c6_y");
        seg(R, 2, 2'b10, 1, 1, 1, 0, 8'd5, "c6_r");
        #2 rst = 1'b0;
        #1;
        sb.push_back('{pack(2'b11, 0, 0, 0, 0, 8'd0), "mid_reset"});
        check();
        @(negedge newClock);
        rst = 1'b1;
        seg(R, 3, 2'b11, 0, 0, 0, 0, 8'd0, "resync_r");
        seg(G, 6, 2'b00, 0, 0, 0, 0, 8'd0, "resync_g");
        seg(Y, 3, 2'b01, 0, 0, 0, 0, 8'd0, "c7_y");
        seg(R, 5, 2'b10, 0, 0, 0, 0, 8'd0, "c7_r");
        seg(G, 6, 2'b00, 0, 0, 0, 1, 8'd1, "c7_done");

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Passive checker on the lamp outputs (green, yellow, red) of the traffic-light controller. Acts as the receiving end of that lamp interface.
- Samples the lamps on the divided tick newClock and decodes the current phase.
- Measures each phase's duration and enforces the G->Y->R->G order. Raises sticky error flags and counts complete, correct cycles.

Parameters:
- GREEN_LEN, 6, required ticks of green per phase (1..255)
- YELLOW_LEN, 3, required ticks of yellow per phase (1..255)
- RED_LEN, 5, required ticks of red per phase (1..255)

Ports:
- newClock  input  1  divided tick clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- green  input  1  green lamp from controller
- yellow  input  1  yellow lamp from controller
- red  input  1  red lamp from controller
- phase  output  2  decoded phase: 00 green, 01 yellow, 10 red, 11 unknown (SYNC/FAULT)
- err_len  output  1  sticky: a fully observed phase had the wrong length
- err_order  output  1  sticky: an illegal phase sequence was seen
- err_pattern  output  1  sticky: a non-one-hot lamp pattern was seen
- cycle_done  output  1  one-tick pulse when a correct G,Y,R cycle completes
- cycle_count  output  8  number of correct cycles, saturates at 255

Behaviour:
- Reset (rst=0, async):
  - state=SYNC, prev_pat=000, run_len=0, cycle_ok=0.
  - phase=11, all err_* =0, cycle_done=0, cycle_count=0.
- Decode:
  - pattern {g,y,r}: 100=G, 010=Y, 001=R.
  - Any other value (000, two lamps on, 111) is ILLEGAL.
- Sampling:
  - Each edge compares the sampled pattern with prev_pat.
  - Same pattern: run_len increments, saturating at 255.
  - Changed pattern: a "transition" is evaluated, run_len is set to 1, and prev_pat is updated.
- All outputs are registered. The effects of a transition are visible immediately after the edge that samples the new pattern.
- States: SYNC, GREEN, YELLOW, RED, FAULT.
- SYNC:
  - Waits for the first legal-to-legal transition and enters the phase of the new pattern.
  - The length of the phase before that transition is not checked.
  - phase output stays 11.
- GREEN, YELLOW, RED:
  - phase output shows the current phase.
  - On a transition, the next pattern must be the successor (G->Y, Y->R, R->G).
  - Correct successor: compare run_len with the parameter for the phase being left.
    - Mismatch: set err_len and clear cycle_ok.
    - Continue in the successor state either way.
  - Wrong legal successor: set err_order and go to FAULT. Length is not checked for that transition.
- cycle tracking:
  - Entering YELLOW from GREEN with a correct green length sets cycle_ok=1.
  - A length error clears cycle_ok.
  - On R->G with cycle_ok=1 and a correct red length: cycle_done=1 for exactly one tick and cycle_count increments (saturating).
  - Every R->G clears cycle_ok.
- ILLEGAL pattern in any state: set err_pattern and go to FAULT. run_len restarts on the illegal pattern.
- FAULT:
  - phase=11, no length checks.
  - Exits to GREEN on the first transition into pattern G from any other pattern.
  - That green phase is measured and checked normally.
- Simultaneous events:
  - An order error takes precedence over a length error on the same transition.
  - An illegal pattern takes precedence over both.
- Sticky flags clear only on reset.
- Saturation: if run_len reaches 255, the length compare uses 255. No wrap-around.
- Reset mid-phase: immediate return to SYNC; counts and flags are discarded.

Decomposition:
- Shared package semaforo_pkg:
  - phase encodings (PH_GREEN=2'b00, PH_YELLOW=2'b01, PH_RED=2'b10, PH_UNKNOWN=2'b11)
  - lamp pattern constants (PAT_G, PAT_Y, PAT_R)
  - monitor state encoding
- One sub-module, semaforo_run_counter: 8-bit saturating run-length counter with synchronous load-to-1 and async active-low reset.

Test Plan:
- Reset, then drive G6,Y3,R5,G -> phase 11 until the first change. After that phase follows 01,10,00. No err_*. No cycle_done in the first cycle, because green was unchecked in SYNC.
- Two consecutive full cycles G6,Y3,R5 after sync -> cycle_done pulses once per R->G, and cycle_count reads 1 then 2.
- Green held 7 ticks in a synced cycle -> err_len=1 after the G->Y edge. No cycle_done at the following R->G. Later correct cycles still increment cycle_count.
- G then R directly (skip yellow) -> err_order=1, phase=11. Then Y, then G -> state GREEN with phase=00; the next correct cycle gives cycle_done.
- Pattern 110 injected for 1 tick during yellow -> err_pattern=1, FAULT, phase=11. Recovery on the next transition to G.
- Assert rst mid-red with flags set -> all outputs return to reset values asynchronously; monitoring resumes in SYNC.
